imem_load_ctrl: RTL and testbench

Controller for the single port of the 32768×32 instruction memory. After reset it holds the core, accepts a length-prefixed program image as a byte stream from the UART receiver, and assembles the bytes into little-endian words. It writes those words into instruction RAM starting at word 0. It then releases the core and hands the read port to the fetch stage, checking every fetch PC for alignment and range.

---
 rtl/imem_load_ctrl.sv | 159 +++++++++++++++
 tb/tb_imem_load_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller: receives a length-prefixed byte image,
// writes little-endian words to instruction RAM, then serves range-checked fetches.
module imem_load_ctrl #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  input  logic                  reload,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_pc,
  output logic                  fetch_grant,
  output logic                  fetch_fault,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_err
);

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_DATA  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [31:0]         MAX_WORDS = 32'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] WCNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                  state_r, next_state_s;
  logic [1:0]              byte_cnt_r;
  logic [23:0]             asm_r;
  logic [ADDR_WIDTH:0]     word_cnt_r;
  logic [ADDR_WIDTH:0]     last_idx_r;
  logic                    mem_we_r;
  logic [ADDR_WIDTH-1:0]   mem_waddr_r;
  logic [31:0]             mem_wdata_r;

  logic                    rx_ready_s;
  logic                    accept_s;
  logic                    word_last_s;
  logic [31:0]             word_s;
  logic                    run_s;
  logic                    fault_s;

  assign rx_ready_s  = (state_r == ST_HDR) || (state_r == ST_DATA);
  assign accept_s    = rx_valid && rx_ready_s;
  assign word_last_s = accept_s && (byte_cnt_r == 2'd3);
  assign word_s      = {rx_data, asm_r};
  assign run_s       = (state_r == ST_RUN);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_HDR;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; the fetch path stays combinational because RAM read is asynchronous
  always_comb begin
    next_state_s = state_r;
    fault_s      = 1'b0;
    case (state_r)
      ST_HDR: begin
        if (word_last_s) begin
          if (word_s == 32'd0) begin
            next_state_s = ST_DRAIN;
          end else if (word_s > MAX_WORDS) begin
            next_state_s = ST_ERR;
          end else begin
            next_state_s = ST_DATA;
          end
        end else begin
          next_state_s = ST_HDR;
        end
      end
      ST_DATA: begin
        if (word_last_s && (word_cnt_r == last_idx_r)) begin
          next_state_s = ST_DRAIN;
        end else begin
          next_state_s = ST_DATA;
        end
      end
      ST_DRAIN: next_state_s = ST_RUN;
      ST_RUN: begin
        fault_s = fetch_req &&
                  ((fetch_pc[1:0] != 2'd0) || (fetch_pc[31:ADDR_WIDTH+2] != '0));
        if (reload) begin
          next_state_s = ST_HDR;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_ERR:  next_state_s = ST_ERR;
      default: next_state_s = ST_ERR;
    endcase
  end

  // Byte assembly, word counting and the registered RAM write port
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_r  <= 2'd0;
      asm_r       <= 24'd0;
      word_cnt_r  <= '0;
      last_idx_r  <= '0;
      mem_we_r    <= 1'b0;
      mem_waddr_r <= '0;
      mem_wdata_r <= 32'd0;
    end else begin
      mem_we_r <= 1'b0;
      if (run_s && reload) begin
        byte_cnt_r <= 2'd0;
        asm_r      <= 24'd0;
        word_cnt_r <= '0;
      end else if (word_last_s) begin
        byte_cnt_r <= 2'd0;
        asm_r      <= 24'd0;
        if (state_r == ST_HDR) begin
          word_cnt_r <= '0;
          last_idx_r <= word_s[ADDR_WIDTH:0] - WCNT_ONE;
        end else begin
          mem_we_r    <= 1'b1;
          mem_waddr_r <= word_cnt_r[ADDR_WIDTH-1:0];
          mem_wdata_r <= word_s;
          word_cnt_r  <= word_cnt_r + WCNT_ONE;
        end
      end else if (accept_s) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        case (byte_cnt_r)
          2'd0:    asm_r[7:0]   <= rx_data;
          2'd1:    asm_r[15:8]  <= rx_data;
          default: asm_r[23:16] <= rx_data;
        endcase
      end else begin
        byte_cnt_r <= byte_cnt_r;
      end
    end
  end

  assign rx_ready    = rx_ready_s;
  assign core_hold   = !run_s;
  assign load_done   = run_s;
  assign load_err    = (state_r == ST_ERR);
  assign fetch_fault = fault_s;
  assign fetch_grant = run_s && fetch_req && !fault_s;
  assign mem_raddr   = run_s ? fetch_pc[ADDR_WIDTH+1:2] : '0;
  assign mem_we      = mem_we_r;
  assign mem_waddr   = mem_waddr_r;
  assign mem_wdata   = mem_wdata_r;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: RAM writes are scoreboarded against a
// queue filled as image words are sent; control/fetch outputs are checked inline.
module tb_imem_load_ctrl;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          reload;
  logic          fetch_req;
  logic [31:0]   fetch_pc;
  logic          fetch_grant;
  logic          fetch_fault;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [AW-1:0] mem_raddr;
  logic          core_hold;
  logic          load_done;
  logic          load_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [AW+31:0] exp_q[$];

  imem_load_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .reload(reload), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .fetch_grant(fetch_grant), .fetch_fault(fetch_fault), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_raddr(mem_raddr),
    .core_hold(core_hold), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Write monitor: every mem_we must match the oldest expected {addr, data}
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr=%0h data=%08h, expected no write", mem_waddr, mem_wdata);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        if ({mem_waddr, mem_wdata} !== e)
          $display("FAIL write: got addr=%0h data=%08h, expected addr=%0h data=%08h",
                   mem_waddr, mem_wdata, e[AW+31:32], e[31:0]);
        if ({mem_waddr, mem_wdata} !== e) n_err++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0; reload = 1'b0; fetch_req = 1'b0; fetch_pc = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns #1 after the edge that accepted the byte
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 50 && rx_ready !== 1'b1; t++) @(negedge clk);
    if (rx_ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL send_byte: rx_ready=%b, expected 1 within 50 cycles", rx_ready);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic wait_done();
    for (int t = 0; t < 10 && load_done !== 1'b1; t++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; reload = 1'b0;
    fetch_req = 1'b1; fetch_pc = 32'h0000_0008;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({rx_ready, core_hold, mem_we, mem_waddr, mem_wdata, fetch_grant, fetch_fault,
         mem_raddr, load_done, load_err} !==
        {1'b1, 1'b1, 1'b0, 15'd0, 32'd0, 1'b0, 1'b0, 15'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values: got rdy=%b hold=%b we=%b wa=%0h wd=%08h gr=%b flt=%b ra=%0h done=%b err=%b, expected 1 1 0 0 0 0 0 0 0 0",
               rx_ready, core_hold, mem_we, mem_waddr, mem_wdata, fetch_grant, fetch_fault,
               mem_raddr, load_done, load_err);
    end
    @(negedge clk);
    rst = 1'b0; fetch_req = 1'b0;
  endtask

  task automatic test_single_word();
    do_reset();
    send_word(32'h0000_0001, 0);
    exp_q.push_back({15'd0, 32'h0000_0013});
    send_word(32'h0000_0013, 0);
    n_cmp++;
    if ({mem_we, core_hold, load_done} !== 3'b110) begin
      n_err++;
      $display("FAIL single_after_last: got we/hold/done=%b%b%b, expected 110", mem_we, core_hold, load_done);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({mem_we, core_hold, load_done} !== 3'b001) begin
      n_err++;
      $display("FAIL single_run: got we/hold/done=%b%b%b, expected 001", mem_we, core_hold, load_done);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL single_pending: got %0d writes outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_fetch();
    logic [31:0] pcs[5];
    logic [AW+1:0] exp[5];
    pcs = '{32'h0000_0008, 32'h0000_0006, 32'h0002_0000, 32'h0001_FFFC, 32'h8000_0004};
    // expected {raddr, grant, fault}
    exp = '{{15'd2, 2'b10}, {15'd1, 2'b01}, {15'd0, 2'b01}, {15'h7FFF, 2'b10}, {15'd1, 2'b01}};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      fetch_req = 1'b1;
      fetch_pc  = pcs[i];
      #1;
      n_cmp++;
      if ({mem_raddr, fetch_grant, fetch_fault} !== exp[i]) begin
        n_err++;
        $display("FAIL fetch pc=%08h: got raddr=%0h grant=%b fault=%b, expected raddr=%0h grant=%b fault=%b",
                 pcs[i], mem_raddr, fetch_grant, fetch_fault, exp[i][AW+1:2], exp[i][1], exp[i][0]);
      end
    end
    @(negedge clk);
    fetch_req = 1'b0;
    fetch_pc  = 32'h0000_0006;
    #1;
    n_cmp++;
    if ({fetch_grant, fetch_fault} !== 2'b00) begin
      n_err++;
      $display("FAIL fetch_idle: got grant=%b fault=%b, expected 0 0", fetch_grant, fetch_fault);
    end
  endtask

  task automatic test_gaps();
    logic [31:0] words[3];
    words = '{32'hAABB_CCDD, 32'h1122_3344, 32'hDEAD_BEEF};
    do_reset();
    send_word(32'd3, 3);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({15'(i), words[i]});
      send_word(words[i], 3);
    end
    wait_done();
    n_cmp++;
    if ({load_done, core_hold} !== 2'b10) begin
      n_err++;
      $display("FAIL gaps_done: got done=%b hold=%b, expected 1 0", load_done, core_hold);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL gaps_pending: got %0d writes outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_zero_header();
    do_reset();
    send_word(32'd0, 0);
    n_cmp++;
    if ({mem_we, rx_ready, core_hold, load_done} !== 4'b0010) begin
      n_err++;
      $display("FAIL zero_drain: got we/rdy/hold/done=%b%b%b%b, expected 0010", mem_we, rx_ready, core_hold, load_done);
    end
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h55;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({rx_ready, core_hold, load_done} !== 3'b001) begin
      n_err++;
      $display("FAIL zero_run: got rdy/hold/done=%b%b%b, expected 001", rx_ready, core_hold, load_done);
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if ({rx_ready, load_done} !== 2'b01) begin
      n_err++;
      $display("FAIL zero_ignore: got rdy/done=%b%b, expected 01", rx_ready, load_done);
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_err();
    do_reset();
    send_word(32'h0000_8001, 0);
    n_cmp++;
    if ({load_err, core_hold, rx_ready, load_done} !== 4'b1100) begin
      n_err++;
      $display("FAIL err_enter: got err/hold/rdy/done=%b%b%b%b, expected 1100", load_err, core_hold, rx_ready, load_done);
    end
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h01; reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if ({load_err, core_hold, rx_ready, load_done} !== 4'b1100) begin
      n_err++;
      $display("FAIL err_sticky: got err/hold/rdy/done=%b%b%b%b, expected 1100", load_err, core_hold, rx_ready, load_done);
    end
    rx_valid = 1'b0;
    do_reset();
    n_cmp++;
    if ({load_err, rx_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL err_cleared: got err=%b rdy=%b, expected 0 1", load_err, rx_ready);
    end
    // largest legal count must enter DATA, not ERR
    send_word(32'h0000_8000, 0);
    n_cmp++;
    if ({load_err, rx_ready, core_hold} !== 3'b011) begin
      n_err++;
      $display("FAIL max_count: got err/rdy/hold=%b%b%b, expected 011", load_err, rx_ready, core_hold);
    end
  endtask

  task automatic test_rst_midload();
    do_reset();
    send_word(32'd1, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({rx_ready, core_hold, mem_we, mem_waddr, mem_wdata, fetch_grant, fetch_fault,
         mem_raddr, load_done, load_err} !==
        {1'b1, 1'b1, 1'b0, 15'd0, 32'd0, 1'b0, 1'b0, 15'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL midload_reset: got rdy=%b hold=%b we=%b wa=%0h wd=%08h done=%b err=%b, expected 1 1 0 0 0 0 0",
               rx_ready, core_hold, mem_we, mem_waddr, mem_wdata, load_done, load_err);
    end
    @(negedge clk);
    rst = 1'b0;
    send_word(32'd1, 0);
    exp_q.push_back({15'd0, 32'h4433_2211});
    send_word(32'h4433_2211, 2);
    wait_done();
    n_cmp++;
    if ({load_done, exp_q.size() == 0} !== 2'b11) begin
      n_err++;
      $display("FAIL midload_reload: got done=%b outstanding=%0d, expected 1 0", load_done, exp_q.size());
    end
  endtask

  task automatic test_reload();
    @(negedge clk);
    reload = 1'b1; fetch_req = 1'b1; fetch_pc = 32'h0000_0004;
    #1;
    n_cmp++;
    if ({fetch_grant, core_hold, mem_raddr} !== {1'b1, 1'b0, 15'd1}) begin
      n_err++;
      $display("FAIL reload_same_cycle: got grant=%b hold=%b raddr=%0h, expected 1 0 1", fetch_grant, core_hold, mem_raddr);
    end
    @(posedge clk);
    #1;
    reload = 1'b0;
    n_cmp++;
    if ({core_hold, rx_ready, load_done, fetch_grant, mem_raddr} !== {1'b1, 1'b1, 1'b0, 1'b0, 15'd0}) begin
      n_err++;
      $display("FAIL reload_hdr: got hold=%b rdy=%b done=%b grant=%b raddr=%0h, expected 1 1 0 0 0",
               core_hold, rx_ready, load_done, fetch_grant, mem_raddr);
    end
    fetch_req = 1'b0;
    send_word(32'd1, 0);
    exp_q.push_back({15'd0, 32'hCAFE_F00D});
    send_word(32'hCAFE_F00D, 1);
    wait_done();
    n_cmp++;
    if ({load_done, exp_q.size() == 0} !== 2'b11) begin
      n_err++;
      $display("FAIL reload_image: got done=%b outstanding=%0d, expected 1 0", load_done, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; reload = 1'b0;
    fetch_req = 1'b0; fetch_pc = 32'd0;
    test_reset();
    test_single_word();
    test_fetch();
    test_gaps();
    test_zero_header();
    test_err();
    test_rst_midload();
    test_reload();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
